// File: rtl/multdiv_unit_if.sv
// Issue/result bundle between the execute stage and the multi-cycle mult/div unit.
// The issuing stage drives ctrl/operands; the unit returns result, exception, rdy and busy.
interface multdiv_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             ctrl_mult;
  logic             ctrl_div;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_mult, ctrl_div, data_a, data_b,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_mult, ctrl_div, data_a, data_b,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiplier (radix-2 Booth) and restoring divider sharing one datapath.
// One op in flight; any start aborts and replaces the current op.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic           clk,
  input logic           clr,
  multdiv_unit_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StMult, StDiv, StFix, StDone} state_t;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   acc_q;   // Booth high half / divider remainder
  logic [WIDTH-1:0] q_q;     // Booth multiplier-low half / dividend-quotient
  logic             qm1_q;   // Booth appended bit
  logic [WIDTH:0]   m_q;     // sign-extended multiplicand or |divisor|
  logic             neg_q;   // operand signs differ
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;
  logic             busy_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;

  always_comb begin
    abs_a = bus.data_a[WIDTH-1] ? (~bus.data_a + 1'b1) : bus.data_a;
    abs_b = bus.data_b[WIDTH-1] ? (~bus.data_b + 1'b1) : bus.data_b;

    unique case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase

    rem_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    rem_ge    = (rem_shift >= m_q);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (bus.ctrl_mult || bus.ctrl_div) begin
      // Start from any state; mult wins when both are requested.
      cnt_q  <= '0;
      acc_q  <= '0;
      qm1_q  <= 1'b0;
      exc_q  <= 1'b0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b1;
      neg_q  <= bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1];
      if (bus.ctrl_mult) begin
        state_q <= StMult;
        q_q     <= bus.data_a;
        m_q     <= {bus.data_b[WIDTH-1], bus.data_b};
      end else begin
        state_q <= StDiv;
        q_q     <= abs_a;
        m_q     <= {1'b0, abs_b};
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          rdy_q <= 1'b0;
        end
        StMult: begin
          if (cnt_q == LastCnt) begin
            state_q  <= StDone;
            result_q <= q_q;
            exc_q    <= (acc_q[WIDTH-1:0] != {WIDTH{q_q[WIDTH-1]}});
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            acc_q <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_q   <= {booth_sum[0], q_q[WIDTH-1:1]};
            qm1_q <= q_q[0];
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDiv: begin
          if (m_q == '0) begin
            state_q  <= StDone;
            result_q <= '0;
            exc_q    <= 1'b1;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
          end else if (cnt_q == LastCnt) begin
            state_q <= StFix;
          end else begin
            acc_q <= rem_ge ? (rem_shift - m_q) : rem_shift;
            q_q   <= {q_q[WIDTH-2:0], rem_ge};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFix: begin
          state_q  <= StDone;
          result_q <= neg_q ? (~q_q + 1'b1) : q_q;
          // Only MIN / -1 yields a same-sign quotient with the top bit set.
          exc_q    <= !neg_q && q_q[WIDTH-1];
          rdy_q    <= 1'b1;
          busy_q   <= 1'b0;
        end
        StDone: begin
          state_q <= StIdle;
          rdy_q   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule
